// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter: data width,
// ALU function codes and the controller state encoding.
`timescale 1ns/1ps
package alu_arbiter_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] FUNC_ADD    = 3'd0;
    localparam logic [2:0] FUNC_SUB    = 3'd1;
    localparam logic [2:0] FUNC_MOVE   = 3'd2;
    localparam logic [2:0] FUNC_LSHIFT = 3'd3;
    localparam logic [2:0] FUNC_RSHIFT = 3'd4;
    localparam logic [2:0] FUNC_AND    = 3'd5;
    localparam logic [2:0] FUNC_NOT    = 3'd6;
    localparam logic [2:0] FUNC_OR     = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Only the arithmetic ops report a meaningful carry out of the ALU.
    function automatic logic carry_kept(input logic [2:0] func);
        return (func == FUNC_ADD) || (func == FUNC_SUB);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two command sources and the arbiter.
`timescale 1ns/1ps
interface alu_arbiter_if;
    import alu_arbiter_pkg::*;

    // Valid/ready: a transfer happens on a rising edge where valid and ready
    // are both high; the source holds valid and its fields until then.
    logic              req_valid_0;
    logic              req_valid_1;
    logic              req_ready_0;
    logic              req_ready_1;
    logic [2:0]        req_op_0;
    logic [2:0]        req_op_1;
    logic [DATA_W-1:0] req_a_0;
    logic [DATA_W-1:0] req_a_1;
    logic [DATA_W-1:0] req_b_0;
    logic [DATA_W-1:0] req_b_1;
    logic              rsp_valid_0;
    logic              rsp_valid_1;
    logic              rsp_ready_0;
    logic              rsp_ready_1;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_cout;

    modport master (
        output req_valid_0, req_valid_1, req_op_0, req_op_1,
               req_a_0, req_a_1, req_b_0, req_b_1, rsp_ready_0, rsp_ready_1,
        input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
               rsp_data, rsp_cout
    );

    modport slave (
        input  req_valid_0, req_valid_1, req_op_0, req_op_1,
               req_a_0, req_a_1, req_b_0, req_b_1, rsp_ready_0, rsp_ready_1,
        output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
               rsp_data, rsp_cout
    );

endinterface

// File: rtl/alu.sv
// Combinational 8-bit ALU with eight functions; cout is the 9th result bit
// for ADD/SUB (borrow on SUB) and the shifted-out bit for the shifts.
`timescale 1ns/1ps
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [2:0]        func,
    output logic [DATA_W-1:0] out,
    output logic              cout
);

    always_comb begin
        out  = '0;
        cout = 1'b0;
        case (func)
            FUNC_ADD:    {cout, out} = {1'b0, in1} + {1'b0, in2};
            FUNC_SUB:    {cout, out} = {1'b0, in1} - {1'b0, in2};
            FUNC_MOVE:   out = in1;
            FUNC_LSHIFT: {cout, out} = {in1, 1'b0};
            FUNC_RSHIFT: {out, cout} = {1'b0, in1};
            FUNC_AND:    out = in1 & in2;
            FUNC_NOT:    out = ~in1;
            FUNC_OR:     out = in1 | in2;
            default:     out = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter_rr_pick2.sv
// Two-way round-robin pick: with both valid, the requester not granted last wins.
`timescale 1ns/1ps
module rr_pick2 (
    input  logic valid_0,
    input  logic valid_1,
    input  logic last,
    output logic gnt_0,
    output logic gnt_1
);

    assign gnt_0 = valid_0 && (!valid_1 || last);
    assign gnt_1 = valid_1 && (!valid_0 || !last);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: accept, execute for one cycle,
// then hold the registered result until the winner takes it.
`timescale 1ns/1ps
module alu_arbiter #(
    parameter int DATA_W    = 8,
    parameter bit INIT_LAST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus,
    output logic         busy,
    output logic [7:0]   op_count,
    output logic [1:0]   dbg_state
);
    import alu_arbiter_pkg::*;

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic              id_q, id_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_cout_q, rsp_cout_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [7:0]        op_count_q, op_count_d;

    logic              gnt_0, gnt_1, is_idle, accept, rsp_taken;
    logic [DATA_W-1:0] alu_out;
    logic              alu_cout;

    rr_pick2 u_pick (
        .valid_0 (bus.req_valid_0),
        .valid_1 (bus.req_valid_1),
        .last    (last_q),
        .gnt_0   (gnt_0),
        .gnt_1   (gnt_1)
    );

    alu u_alu (
        .in1  (a_q),
        .in2  (b_q),
        .func (op_q),
        .out  (alu_out),
        .cout (alu_cout)
    );

    assign is_idle   = (state_q == ST_IDLE);
    assign accept    = is_idle && (gnt_0 || gnt_1);
    // Only the winner's rsp_ready can complete the response.
    assign rsp_taken = id_q ? bus.rsp_ready_1 : bus.rsp_ready_0;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_data_d  = rsp_data_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_valid_d = rsp_valid_q;
        op_count_d  = op_count_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    id_d    = gnt_1;
                    last_d  = gnt_1;
                    op_d    = gnt_1 ? bus.req_op_1 : bus.req_op_0;
                    a_d     = gnt_1 ? bus.req_a_1  : bus.req_a_0;
                    b_d     = gnt_1 ? bus.req_b_1  : bus.req_b_0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = alu_out;
                rsp_cout_d  = carry_kept(op_q) ? alu_cout : 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_taken) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 8'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= INIT_LAST;
            id_q        <= 1'b0;
            op_q        <= 3'd0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_data_q  <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            op_count_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_data_q  <= rsp_data_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_valid_q <= rsp_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    assign bus.req_ready_0 = is_idle && gnt_0;
    assign bus.req_ready_1 = is_idle && gnt_1;
    assign bus.rsp_valid_0 = rsp_valid_q && !id_q;
    assign bus.rsp_valid_1 = rsp_valid_q && id_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_cout    = rsp_cout_q;
    assign busy            = !is_idle;
    assign op_count        = op_count_q;
    assign dbg_state       = state_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the 8-bit ALU (3-bit func) between two requesters using a round-robin arbiter and a valid/ready handshake.
- Latches the winning request's operands, drives the ALU for one cycle, registers the result and carry, and returns them to the winner on a response handshake.
- Sits between the ALU and the two command sources (e.g. two datapath sequencers).

Parameters:
- DATA_W, 8, operand/result width; must be 8 to match the ALU.
- INIT_LAST, 1, reset value of the last-grant pointer; 1 gives requester 0 first priority.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- req_valid_0 / req_valid_1  input  1  request present from requester 0/1
- req_ready_0 / req_ready_1  output  1  request accepted this cycle (combinational)
- req_op_0 / req_op_1  input  3  ALU func: 0 ADD, 1 SUB, 2 MOVE, 3 LSHIFT, 4 RSHIFT, 5 AND, 6 NOT, 7 OR
- req_a_0 / req_a_1, req_b_0 / req_b_1  input  8  operands in1, in2
- rsp_valid_0 / rsp_valid_1  output  1  response available for requester 0/1
- rsp_ready_0 / rsp_ready_1  input  1  requester consumes response
- rsp_data  output  8  registered ALU result, shared by both requesters
- rsp_cout  output  1  registered carry
- busy  output  1  high in EXEC or RESP
- op_count  output  8  completed-operation counter

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (async, any state): state = IDLE, last = INIT_LAST, latched op/operands/id = 0, rsp_data = 0, rsp_cout = 0, all rsp_valid = 0, busy = 0, op_count = 0.
  - A transaction in flight at reset is dropped; no response is produced.

IDLE:
- Only one req_ready is ever high. Grant rules:
  - Only one valid: grant it.
  - Both valid: grant the requester != last.
  - Neither valid: no grant.
- On accept (valid && ready):
  - Latch op, a, b and id = granted index.
  - Set last = id.
  - Next state EXEC.
- req_ready is 0 in EXEC and RESP.

EXEC (exactly one cycle):
- ALU in1/in2/func are driven from the latched registers.
- At the end of the cycle:
  - rsp_data <= ALU result.
  - rsp_cout <= ALU Cout when op is ADD or SUB, else 0.
  - rsp_valid_id <= 1.
  - Next state RESP.

RESP:
- rsp_valid_id, rsp_data and rsp_cout are held stable until rsp_ready_id = 1.
- On that cycle: rsp_valid_id <= 0, op_count <= op_count + 1 (wraps 255 -> 0), next state IDLE.
- rsp_ready of the non-granted requester is ignored.
- rsp_valid of the non-granted requester is never asserted.

Latency and throughput:
- Accept in cycle N -> rsp_valid high in cycle N+2.
- Minimum 3 cycles per operation (accept, EXEC, RESP with rsp_ready already high). No new accept occurs in the cycle the response completes.

Requester obligations and other rules:
- A requester holds valid and its fields stable until accepted.
- A valid held while the other requester is served is granted next (no starvation).
- Simultaneous rsp handshake and new req_valid: the request waits for IDLE.
- Inputs in X/undefined ops: there are none; all 8 func codes are legal.

Decomposition:
- Shared package holds:
  - the ALU func localparams (ADD=0 ... OR=7);
  - the state encoding (IDLE=0, EXEC=1, RESP=2, 2-bit);
  - DATA_W.
- Sub-modules:
  - The existing ALU module is instantiated inside.
  - One natural new sub-module, rr_pick2: combinational 2-way round-robin grant from {valid_0, valid_1, last} -> {gnt_0, gnt_1}.

Test Plan:
- Reset, then req_valid_0 with ADD a=200 b=100; rsp_ready_0=1 -> req_ready_0 in cycle N, rsp_valid_0 in N+2, rsp_data=44, rsp_cout=1, op_count=1.
- Both valid at once after reset: r0 AND 0xF0,0x3C; r1 OR 0x0F,0x30 -> r0 served first (rsp_data=0x30), then r1 (rsp_data=0x3F); r1 never sees rsp_valid during r0's response.
- Requester 0 holds valid continuously with back-to-back ops while requester 1 is also valid -> grants alternate 0,1,0,1; neither is starved.
- Hold rsp_ready_0=0 for 5 cycles after SUB a=0x10 b=0x01 -> rsp_valid_0 and rsp_data=0x0F stay stable, busy=1, req_ready_1=0 throughout; consumed on the 6th cycle.
- LSHIFT a=0x81 -> rsp_data=0x02, rsp_cout=0 (carry masked for non-ADD/SUB).
- Assert rst during EXEC -> all outputs 0 immediately; no rsp_valid afterwards. Run 256 ops -> op_count wraps to 0.
